// File: rtl/tff_chain_pkg.sv
// tff_chain_pkg: shared state encoding and default sizing for the toggle-chain sequencer
package tff_chain_pkg;
  localparam int N_STAGES_DEF = 4;
  localparam int LEN_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: one toggle flop with synchronous clear; ports clk, rst (async active-low), t (toggle), sclr (sync clear, wins over t), q
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic sclr,
  output logic q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= sclr ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_chain_seq.sv
// tff_chain_seq: runs an N-stage cascaded T-flop chain for a commanded number of enabled cycles, then pulses done
// ports: clk, rst (async active-low); cmd_valid/cmd_ready/cmd_len/cmd_clr command handshake;
//        pause (level hold), abort (early stop); busy, done, aborted status; chain_q stage outputs
module tff_chain_seq
  import tff_chain_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_clr,
  input  logic                pause,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [N_STAGES-1:0] chain_q
);
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic clr_l;
  logic en_chain;
  logic [N_STAGES-1:0] t;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign en_chain = (state == RUN) & ~pause & ~abort & (cnt != '0);
  // stage 0 always toggles when enabled; stage i toggles when stage i-1 currently reads 1
  assign t = {N_STAGES{en_chain}} & {chain_q[N_STAGES-2:0], 1'b1};
  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[g]),
      .sclr(state == LOAD && clr_l),
      .q   (chain_q[g])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      clr_l <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cnt <= cmd_len;
          clr_l <= cmd_clr;
          state <= LOAD;
        end
        LOAD: state <= RUN;
        RUN:
          // abort outranks both pause and the zero-length exit
          if (abort) begin
            state <= IDLE;
            done <= 1'b1;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            state <= IDLE;
            done <= 1'b1;
          end else if (!pause) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state <= IDLE;
              done <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tff_chain_seq.sv
// tb_tff_chain_seq: scoreboard bench for tff_chain_seq against a cycle-level behavioural model
module tb_tff_chain_seq;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, cmd_clr = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [W-1:0] cmd_len = '0;
  logic cmd_ready, busy, done, aborted;
  logic [N-1:0] chain_q;
  tff_chain_seq #(.N_STAGES(N), .LEN_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_clr(cmd_clr), .pause(pause), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .chain_q(chain_q)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [N-1:0] chain; logic ab; int due;} exp_t;
  exp_t sb[$];
  exp_t me;
  int n_checks = 0, n_fail = 0;
  logic [N-1:0] m_chain = '0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
    end
  endtask
  function automatic logic [N-1:0] tstep(input logic [N-1:0] q);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (i == 0 || q[i-1]) ? ~q[i] : q[i];
    return r;
  endfunction
  always @(negedge clk)
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending run at cycle %0d", cyc);
        end else begin
          me = sb.pop_front();
          chk("chain_at_done", chain_q, me.chain);
          chk("aborted_at_done", aborted, me.ab);
          chk("done_cycle", cyc, me.due);
        end
      end else chk("aborted_low", aborted, 0);
    end
  task automatic run(input int len, input bit clr, input int abort_at, input int p0, input int pl, input bit hold);
    logic [N-1:0] c;
    int tg, jend;
    logic ab;
    c = clr ? '0 : m_chain;
    tg = 0;
    ab = 1'b0;
    jend = 0;
    for (int j = 1; jend == 0; j++) begin
      if (abort_at == j) begin
        ab = 1'b1;
        jend = j;
      end else if (len == 0) jend = j;
      else if (!(j >= p0 && j < p0 + pl)) begin
        c = tstep(c);
        tg++;
        if (tg == len) jend = j;
      end
    end
    m_chain = c;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_len = W'(len);
    cmd_clr = clr;
    @(posedge clk);
    #1;
    cmd_valid = hold;
    cmd_len = W'($urandom);
    cmd_clr = 1'($urandom);
    sb.push_back('{c, ab, cyc + 1 + jend});
    @(posedge clk);
    for (int j = 1; j <= jend; j++) begin
      #1;
      pause = (j >= p0 && j < p0 + pl);
      abort = (abort_at == j);
      chk("busy_run", busy, 1);
      chk("ready_run", cmd_ready, 0);
      if (j == jend) cmd_valid = 1'b0;
      @(posedge clk);
    end
    #1;
    pause = 1'b0;
    abort = 1'b0;
    cmd_valid = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_chain", chain_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_aborted", aborted, 0);
    @(negedge clk);
    rst = 1'b1;
    run(5, 1'b1, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("ex1_final", chain_q, 4'b1001);
    run(3, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("ex2_final", chain_q, 4'b0000);
    run(2, 1'b0, 0, 0, 0, 1'b0);
    run(0, 1'b1, 0, 0, 0, 1'b0);
    run(6, 1'b0, 0, 3, 3, 1'b1);
    run(10, 1'b1, 3, 0, 0, 1'b0);
    @(negedge clk);
    chk("abort_final", chain_q, 4'b0010);
    repeat (14) begin
      int len, ab_at;
      len = $urandom_range(0, 12);
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : 0;
      run(len, 1'($urandom), ab_at, $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom));
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = 8'd20;
    cmd_clr = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_chain", chain_q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 1);
    m_chain = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    run(4, 1'b0, 0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
